// File: rtl/counter_sync_mod_n.sv
// Parametrised synchronous modulo-N up/down counter with 74161-style ENP/ENT
// cascade enables, synchronous clear/load and a registered wrap pulse.
module counter_sync_mod_n #(
  parameter int unsigned     WIDTH       = 4,
  parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
  parameter longint unsigned RESET_VALUE = 64'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SCLR_n,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC_PULSE
);

  localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  // Clear beats load beats count; a clear or load suppresses the step and
  // therefore also the wrap pulse on that edge.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (!SCLR_n) begin
      q_d = '0;
    end else if (!LOAD_n) begin
      q_d = D;
    end else if (ENP && ENT) begin
      if (UP) begin
        if (q_q >= TERM) begin
          q_d  = '0;
          tc_d = (q_q == TERM);
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (q_q == '0) begin
          q_d  = TERM;
          tc_d = 1'b1;
        end else if (q_q > TERM) begin
          q_d = TERM;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q  <= RST_Q;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  // Carry is combinational so a chained stage sees it on the same edge.
  assign RCO      = ENT & (UP ? (q_q == TERM) : (q_q == '0));
  assign Q        = q_q;
  assign TC_PULSE = tc_q;

endmodule
